pipeline_decode: RTL and testbench

DECODE stage. Sits directly downstream of the fetch stage and upstream of the ALU stage.
Each cycle it latches the (pc, instruction) pair presented by fetch into an input slot and decodes it. It reads operands from an internal register file with write-back bypass, then issues a registered micro-bundle to the ALU stage.
It also drives the fetch-side control: stall_request for load-use hazards and early_branch_cmd for jump classification.

---
 rtl/mips_defs.sv | 89 ++++++++
 rtl/regfile.sv | 40 ++++
 rtl/pipeline_decode.sv | 96 +++++++++
 tb/tb_pipeline_decode.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS decode definitions.
// Opcodes, functs, branch command codes and field decode.
package mips_defs;

  localparam logic [1:0]  LOAD_USE_STALL = 2'd1;
  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

  typedef enum logic [3:0] {
    EB_NONE   = 4'h0,
    EB_JUMP   = 4'h1,
    EB_BRANCH = 4'h2,
    EB_JREG   = 4'h3
  } eb_cmd_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic        load;
    logic        use_rs;
    logic        use_rt;
    eb_cmd_t     cmd;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    logic [5:0] op;
    dec_t d;
    op = inst[31:26];
    d.rs = inst[25:21];
    d.rt = inst[20:16];
    d.load = op inside {[OP_LB:OP_LHU]};
    d.use_rs = !(op inside {OP_J, OP_JAL, OP_LUI});
    d.use_rt = op inside {OP_RTYPE, OP_BEQ, OP_BNE,
                          [OP_SB:OP_SW]};
    unique case (1'b1)
      op inside {OP_ANDI, OP_ORI, OP_XORI}:
        d.imm = {16'h0, inst[15:0]};
      op == OP_LUI:
        d.imm = {inst[15:0], 16'h0};
      default:
        d.imm = {{16{inst[15]}}, inst[15:0]};
    endcase
    unique case (1'b1)
      op == OP_RTYPE:
        d.dest = inst[15:11];
      op == OP_JAL:
        d.dest = 5'd31;
      (op inside {[OP_ADDI:OP_LUI]}) || d.load:
        d.dest = inst[20:16];
      default:
        d.dest = 5'd0;
    endcase
    unique case (1'b1)
      op inside {OP_J, OP_JAL}:
        d.cmd = EB_JUMP;
      op inside {OP_REGIMM, [OP_BEQ:OP_BGTZ]}:
        d.cmd = EB_BRANCH;
      (op == OP_RTYPE) &&
      (inst[5:0] inside {FN_JR, FN_JALR}):
        d.cmd = EB_JREG;
      default:
        d.cmd = EB_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two async reads, one write.
// r0 is hardwired to zero; same-cycle writes bypass to reads.
module regfile (
  input  logic        clk,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        wb_enable,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data
);

  logic [31:0] mem [32];

  // write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wb_enable && wb_addr != 5'd0)
      mem[wb_addr] <= wb_data;
  end

  // rs read with r0 and write-back bypass
  always_comb begin
    rs_data = mem[rs_addr];
    if (rs_addr == 5'd0)
      rs_data = '0;
    else if (wb_enable && wb_addr == rs_addr)
      rs_data = wb_data;
  end

  // rt read with r0 and write-back bypass
  always_comb begin
    rt_data = mem[rt_addr];
    if (rt_addr == 5'd0)
      rt_data = '0;
    else if (wb_enable && wb_addr == rt_addr)
      rt_data = wb_data;
  end

endmodule

// File: rtl/pipeline_decode.sv
// Decode stage: input slot, operand read, issue to ALU.
// Also drives load-use stall and early branch class to fetch.
module pipeline_decode #(
  parameter logic [1:0]  LOAD_USE_STALL = 2'd1,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        flush,
  input  logic        wb_enable,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [1:0]  stall_request,
  output logic [3:0]  early_branch_cmd,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val,
  output logic [31:0] imm_ext,
  output logic [4:0]  dest_reg,
  output logic        is_load
);

  import mips_defs::*;

  logic        slot_valid;
  logic [31:0] slot_pc;
  logic [31:0] slot_inst;
  dec_t        dec;
  logic        hazard;
  logic        issue;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  // field decode of the held slot
  always_comb begin
    dec = decode(slot_inst);
  end

  regfile u_rf (
    .clk       (clk),
    .rs_addr   (dec.rs),
    .rt_addr   (dec.rt),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .wb_enable (wb_enable),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  // hazard compares the slot against the load just issued
  always_comb begin
    hazard = slot_valid && is_load && dest_reg != 5'd0 &&
             ((dec.use_rs && dec.rs == dest_reg) ||
              (dec.use_rt && dec.rt == dest_reg));
    issue = slot_valid && !hazard && !flush;
    stall_request = (hazard && !flush) ? LOAD_USE_STALL : 2'd0;
    early_branch_cmd = issue ? dec.cmd : EB_NONE;
  end

  // slot capture and registered issue bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= 1'b0;
      slot_pc    <= '0;
      slot_inst  <= '0;
      pc_out     <= '0;
      inst_out   <= '0;
      rs_val     <= '0;
      rt_val     <= '0;
      imm_ext    <= '0;
      dest_reg   <= '0;
      is_load    <= 1'b0;
    end else begin
      if (flush) begin
        slot_valid <= 1'b0;
        slot_pc    <= '0;
        slot_inst  <= '0;
      end else if (!hazard) begin
        slot_valid <= inst_in != '0;
        slot_pc    <= pc_in;
        slot_inst  <= inst_in;
      end
      pc_out   <= issue ? slot_pc : '0;
      inst_out <= issue ? slot_inst : NOP_WORD;
      rs_val   <= issue ? rs_data : '0;
      rt_val   <= issue ? rt_data : '0;
      imm_ext  <= issue ? dec.imm : '0;
      dest_reg <= issue ? dec.dest : '0;
      is_load  <= issue && dec.load;
    end
  end

endmodule

// File: tb/tb_pipeline_decode.sv
// Scoreboard bench for the decode stage.
// Fetch-side driver plus independent output monitor.
module tb_pipeline_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic        flush;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  stall_request;
  logic [3:0]  early_branch_cmd;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_ext;
  logic [4:0]  dest_reg;
  logic        is_load;

  pipeline_decode dut (
    .clk              (clk),
    .rst              (rst),
    .pc_in            (pc_in),
    .inst_in          (inst_in),
    .flush            (flush),
    .wb_enable        (wb_enable),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .stall_request    (stall_request),
    .early_branch_cmd (early_branch_cmd),
    .pc_out           (pc_out),
    .inst_out         (inst_out),
    .rs_val           (rs_val),
    .rt_val           (rt_val),
    .imm_ext          (imm_ext),
    .dest_reg         (dest_reg),
    .is_load          (is_load)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        ld;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc;
  logic [31:0] m_regs [32];
  logic        m_sv;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_ld;
  logic [4:0]  m_dst;
  int          ops [26] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9,
                            10, 11, 12, 13, 14, 15,
                            32, 33, 34, 35, 36, 37,
                            40, 41, 42, 43};
  int          fns [4] = '{'h21, 'h08, 'h09, 'h23};

  function automatic int opc(input logic [31:0] i);
    return int'(i[31:26]);
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    int op = opc(i);
    if (op >= 12 && op <= 14) return i & 32'h0000_FFFF;
    if (op == 15) return i << 16;
    return {{16{i[15]}}, i[15:0]};
  endfunction

  function automatic logic m_load(input logic [31:0] i);
    return opc(i) >= 32 && opc(i) <= 37;
  endfunction

  function automatic logic [4:0] m_dest(input logic [31:0] i);
    int op = opc(i);
    if (op == 0) return i[15:11];
    if (op == 3) return 5'd31;
    if ((op >= 8 && op <= 15) || m_load(i)) return i[20:16];
    return 5'd0;
  endfunction

  function automatic logic m_urs(input logic [31:0] i);
    int op = opc(i);
    return !(op == 2 || op == 3 || op == 15);
  endfunction

  function automatic logic m_urt(input logic [31:0] i);
    int op = opc(i);
    return op == 0 || op == 4 || op == 5 ||
           (op >= 40 && op <= 43);
  endfunction

  function automatic logic [3:0] m_cmd(input logic [31:0] i);
    int op = opc(i);
    if (op == 2 || op == 3) return 4'h1;
    if (op == 1 || (op >= 4 && op <= 7)) return 4'h2;
    if (op == 0 && (i[5:0] == 6'h08 || i[5:0] == 6'h09))
      return 4'h3;
    return 4'h0;
  endfunction

  function automatic logic m_hazard();
    logic a;
    logic b;
    a = m_urs(m_inst) && m_inst[25:21] == m_dst;
    b = m_urt(m_inst) && m_inst[20:16] == m_dst;
    return m_sv && m_ld && m_dst != 5'd0 && (a || b);
  endfunction

  function automatic logic [31:0] m_read(
    input logic [4:0] a, input logic we,
    input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] r_ty(
    input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ty(
    input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h",
               name, act, req);
    end
  endtask

  task automatic m_clear();
    m_sv = 1'b0;
    m_pc = '0;
    m_inst = '0;
    m_ld = 1'b0;
    m_dst = '0;
  endtask

  // one fetch cycle: drive, check fetch-side outputs, advance model
  task automatic step(input logic [31:0] pcv,
                      input logic [31:0] inst,
                      input logic fl, input logic we,
                      input logic [4:0] wa,
                      input logic [31:0] wd);
    logic hz;
    logic [1:0] es;
    logic [3:0] ec;
    exp_t e;
    @(negedge clk);
    pc_in = pcv;
    inst_in = inst;
    flush = fl;
    wb_enable = we;
    wb_addr = wa;
    wb_data = wd;
    hz = m_hazard();
    es = (hz && !fl) ? 2'd1 : 2'd0;
    ec = (m_sv && !hz && !fl) ? m_cmd(m_inst) : 4'h0;
    #1;
    chk("stall_request", 64'(stall_request), 64'(es));
    chk("early_branch_cmd", 64'(early_branch_cmd), 64'(ec));
    if (fl) begin
      m_clear();
    end else if (hz) begin
      m_ld = 1'b0;
      m_dst = '0;
    end else begin
      if (m_sv) begin
        e.pc = m_pc;
        e.inst = m_inst;
        e.rs = m_read(m_inst[25:21], we, wa, wd);
        e.rt = m_read(m_inst[20:16], we, wa, wd);
        e.imm = m_imm(m_inst);
        e.dest = m_dest(m_inst);
        e.ld = m_load(m_inst);
        q.push_back(e);
        m_ld = e.ld;
        m_dst = e.dest;
      end else begin
        m_ld = 1'b0;
        m_dst = '0;
      end
      m_sv = inst != 32'h0;
      m_pc = pcv;
      m_inst = inst;
    end
    if (we && wa != 5'd0) m_regs[wa] = wd;
  endtask

  // fetch model: wait out stalls, then present one word
  task automatic fetch_x(input logic [31:0] inst,
                         input logic fl, input logic we,
                         input logic [4:0] wa,
                         input logic [31:0] wd);
    for (int n = 0; n < 4 && !fl && m_hazard(); n++)
      step(pc, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(pc, inst, fl, we, wa, wd);
    pc = pc + 32'd4;
  endtask

  task automatic fetch(input logic [31:0] inst);
    fetch_x(inst, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_pc_out"}, 64'(pc_out), 64'h0);
    chk({tag, "_inst_out"}, 64'(inst_out), 64'h0);
    chk({tag, "_rs_val"}, 64'(rs_val), 64'h0);
    chk({tag, "_rt_val"}, 64'(rt_val), 64'h0);
    chk({tag, "_imm_ext"}, 64'(imm_ext), 64'h0);
    chk({tag, "_dest_reg"}, 64'(dest_reg), 64'h0);
    chk({tag, "_is_load"}, 64'(is_load), 64'h0);
    chk({tag, "_stall"}, 64'(stall_request), 64'h0);
    chk({tag, "_cmd"}, 64'(early_branch_cmd), 64'h0);
  endtask

  function automatic logic [31:0] rand_inst();
    int op;
    if ($urandom_range(0, 7) == 0) return 32'h0;
    op = ops[$urandom_range(0, 25)];
    if (op == 0)
      return r_ty($urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), fns[$urandom_range(0, 3)]);
    return i_ty(op, $urandom_range(0, 7), $urandom_range(0, 7),
                int'($urandom_range(0, 65535)));
  endfunction

  // monitor: every issued word is matched against the queue
  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (!rst && inst_out != 32'h0) begin
      a = {pc_out, inst_out, rs_val, rt_val,
           imm_ext, dest_reg, is_load};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %0h required none",
                 a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL issue: got %0h required %0h", a, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pc_in = '0;
    inst_in = '0;
    flush = 1'b0;
    wb_enable = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    pc = 32'h0000_1000;
    m_clear();
    m_regs[0] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i < 32; i++)
      step(pc, 32'h0, 1'b0, 1'b1, 5'(i), $urandom);

    // ADDIU r2,r0,5 then write-back, then ADDU r3,r2,r2
    fetch(i_ty('h09, 0, 2, 5));
    fetch_x(r_ty(2, 2, 3, 'h21), 1'b0, 1'b1, 5'd2, 32'd5);
    fetch(32'h0);
    @(posedge clk);
    #1;
    chk("addu_rs_val", 64'(rs_val), 64'd5);
    chk("addu_dest", 64'(dest_reg), 64'd3);

    // load-use: LW r4,0(r1) then ADDU r5,r4,r4
    fetch(i_ty('h23, 1, 4, 0));
    fetch(r_ty(4, 4, 5, 'h21));
    fetch(32'h0);
    fetch(32'h0);

    // same-cycle bypass and r0 write suppression
    fetch(r_ty(7, 0, 8, 'h21));
    fetch_x(32'h0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    fetch(r_ty(0, 0, 9, 'h21));
    fetch_x(32'h0, 1'b0, 1'b1, 5'd0, 32'h1234_5678);
    fetch(32'h0);

    // branch classes, then load feeding a branch
    fetch({6'h02, 26'h40});
    fetch(i_ty('h04, 1, 2, 3));
    fetch(r_ty(31, 0, 0, 'h08));
    fetch(i_ty('h23, 1, 6, 4));
    fetch(i_ty('h04, 6, 1, 8));
    fetch(32'h0);
    fetch(32'h0);

    // flush while a load-use hazard is pending
    fetch(i_ty('h23, 1, 4, 0));
    fetch(r_ty(4, 4, 5, 'h21));
    fetch_x(i_ty('h09, 0, 10, 1), 1'b1, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    chk("flush_inst_out", 64'(inst_out), 64'h0);
    chk("flush_dest_reg", 64'(dest_reg), 64'h0);
    fetch(i_ty('h09, 0, 11, 2));
    fetch(32'h0);
    fetch(32'h0);

    // reset while a stall is being requested
    fetch(i_ty('h23, 1, 4, 0));
    fetch(r_ty(4, 4, 5, 'h21));
    @(negedge clk);
    inst_in = '0;
    flush = 1'b0;
    wb_enable = 1'b0;
    #1;
    chk("stall_before_reset", 64'(stall_request), 64'd1);
    rst = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    fetch(i_ty('h09, 0, 12, 7));
    fetch(32'h0);
    fetch(32'h0);

    // randomized traffic with write-back and occasional flush
    for (int k = 0; k < 400; k++)
      fetch_x(rand_inst(),
              $urandom_range(0, 11) == 0,
              $urandom_range(0, 2) == 0,
              5'($urandom_range(0, 7)),
              $urandom);
    repeat (3) fetch(32'h0);
    @(posedge clk);
    #2;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
